// File: rtl/vdpram_pkg.sv
// vdpram_pkg: shared types and helpers for the multi-channel VDP RAM arbiter.
// Grant-source encoding, channel limits and the byte-lane write mask.
package vdpram_pkg;

  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_VDP,
    GNT_CPU,
    GNT_WB
  } gnt_src_e;

  localparam int MAX_VDP   = 4;
  localparam int VDP_IDX_W = 2;
  // Widest supported word is MAX_LANES bytes
  localparam int MAX_LANES = 8;

  function automatic logic [MAX_LANES-1:0] lane_mask(
    input logic                 full,
    input logic [MAX_LANES-1:0] sel
  );
    return full ? {MAX_LANES{1'b1}} : sel;
  endfunction

endpackage

// File: rtl/vdpram_arb_grant.sv
// vdpram_arb_grant: combinational fixed-priority grant encoder.
// Lowest VDP channel first, then the CPU port, then Wishbone.
module vdpram_arb_grant
  import vdpram_pkg::*;
#(
  parameter int NUM_VDP = 2
) (
  input  logic [NUM_VDP-1:0]   eff,
  input  logic                 cpu_elig,
  input  logic                 wb_elig,
  output gnt_src_e             src,
  output logic [VDP_IDX_W-1:0] idx
);

  logic vdp_hit;
  logic cpu_hit;
  logic wb_hit;

  assign vdp_hit = |eff;
  assign cpu_hit = cpu_elig & ~vdp_hit;
  assign wb_hit  = wb_elig & ~vdp_hit & ~cpu_elig;

  always_comb begin
    idx = '0;
    for (int i = NUM_VDP - 1; i >= 0; i--) begin
      if (eff[i]) idx = VDP_IDX_W'(i);
    end
  end

  always_comb begin
    unique case (1'b1)
      vdp_hit: src = GNT_VDP;
      cpu_hit: src = GNT_CPU;
      wb_hit:  src = GNT_WB;
      default: src = GNT_NONE;
    endcase
  end

endmodule

// File: rtl/vdpram_arbiter.sv
// vdpram_arbiter: single-port RAM shared by NUM_VDP VDP readers, CPU, Wishbone.
// Define VDPRAM_OVERRUN_EN to add the sticky vdp_overrun flag.
module vdpram_arbiter
  import vdpram_pkg::*;
#(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_VDP    = 2
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          clk_en_vdp,
  input  logic [NUM_VDP-1:0]            vdp_read,
  input  logic [NUM_VDP*ADDR_WIDTH-1:0] vdp_raddr,
  output logic [NUM_VDP*DATA_WIDTH-1:0] vdp_rdata,
  output logic [NUM_VDP-1:0]            vdp_rvalid,
`ifdef VDPRAM_OVERRUN_EN
  output logic                          vdp_overrun,
`endif
  input  logic                          cpu_req,
  input  logic                          cpu_we,
  input  logic [ADDR_WIDTH-1:0]         cpu_addr,
  input  logic [DATA_WIDTH-1:0]         cpu_wdata,
  output logic [DATA_WIDTH-1:0]         cpu_rdata,
  output logic                          cpu_ack,
  input  logic [ADDR_WIDTH-1:0]         wb_adr_i,
  input  logic [DATA_WIDTH-1:0]         wb_dat_i,
  output logic [DATA_WIDTH-1:0]         wb_dat_o,
  input  logic                          wb_we_i,
  input  logic [DATA_WIDTH/8-1:0]       wb_sel_i,
  input  logic                          wb_stb_i,
  input  logic                          wb_cyc_i,
  output logic                          wb_ack_o
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [NUM_VDP-1:0]    pending;
  logic [NUM_VDP-1:0]    cap;
  logic [NUM_VDP-1:0]    eff;
  logic [NUM_VDP-1:0]    gnt_vdp;
  logic [ADDR_WIDTH-1:0] lat       [NUM_VDP];
  logic [ADDR_WIDTH-1:0] chan_addr [NUM_VDP];

  logic                  cpu_elig;
  logic                  wb_elig;
  gnt_src_e              src;
  logic [VDP_IDX_W-1:0]  idx;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_we;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [MAX_LANES-1:0]  mask_full;
  logic [LANES-1:0]      mem_be;
  logic                  lane_unused;

  assign cap      = {NUM_VDP{clk_en_vdp}} & vdp_read;
  assign eff      = pending | cap;
  assign cpu_elig = cpu_req & ~cpu_ack;
  assign wb_elig  = wb_cyc_i & wb_stb_i & ~wb_ack_o;

  vdpram_arb_grant #(
    .NUM_VDP (NUM_VDP)
  ) u_grant (
    .eff      (eff),
    .cpu_elig (cpu_elig),
    .wb_elig  (wb_elig),
    .src      (src),
    .idx      (idx)
  );

  // A pending channel reads its latched address, even if re-captured now
  always_comb begin
    for (int i = 0; i < NUM_VDP; i++) begin
      chan_addr[i] = pending[i] ? lat[i]
                   : vdp_raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
      gnt_vdp[i]   = (src == GNT_VDP) && (idx == VDP_IDX_W'(i));
    end
  end

  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = cpu_wdata;
    for (int i = 0; i < NUM_VDP; i++) begin
      if (gnt_vdp[i]) mem_addr = chan_addr[i];
    end
    unique case (src)
      GNT_CPU: begin
        mem_addr = cpu_addr;
        mem_we   = cpu_we;
      end
      GNT_WB: begin
        mem_addr  = wb_adr_i;
        mem_we    = wb_we_i;
        mem_wdata = wb_dat_i;
      end
      default: ;
    endcase
  end

  assign mask_full   = lane_mask(src == GNT_CPU, MAX_LANES'(wb_sel_i));
  assign mem_be      = mask_full[LANES-1:0];
  assign lane_unused = &{1'b0, mask_full};

  always_ff @(posedge clk) begin
    if (mem_we && reset_n) begin
      for (int b = 0; b < LANES; b++) begin
        if (mem_be[b]) mem[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending    <= '0;
      vdp_rvalid <= '0;
      vdp_rdata  <= '0;
      cpu_rdata  <= '0;
      cpu_ack    <= 1'b0;
      wb_dat_o   <= '0;
      wb_ack_o   <= 1'b0;
      for (int i = 0; i < NUM_VDP; i++) lat[i] <= '0;
    end else begin
      vdp_rvalid <= gnt_vdp;
      cpu_ack    <= (src == GNT_CPU);
      wb_ack_o   <= (src == GNT_WB);
      for (int i = 0; i < NUM_VDP; i++) begin
        if (gnt_vdp[i]) begin
          vdp_rdata[i*DATA_WIDTH +: DATA_WIDTH] <= mem[mem_addr];
        end
        if (cap[i]) lat[i] <= vdp_raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
        pending[i] <= gnt_vdp[i] ? (pending[i] & cap[i]) : eff[i];
      end
      if (src == GNT_CPU && !cpu_we) cpu_rdata <= mem[mem_addr];
      if (src == GNT_WB && !wb_we_i) wb_dat_o <= mem[mem_addr];
    end
  end

`ifdef VDPRAM_OVERRUN_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vdp_overrun <= 1'b0;
    end else if (|(cap & pending & ~gnt_vdp)) begin
      vdp_overrun <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_vdpram_arbiter.sv
// tb_vdpram_arbiter: directed and random stimulus against a behavioural model.
// Build with VDPRAM_OVERRUN_EN to also check the overrun flag.
module tb_vdpram_arbiter;

  localparam int AW = 14;
  localparam int DW = 16;
  localparam int NV = 2;

  logic          clk;
  logic          reset_n;
  logic          clk_en_vdp;
  logic [NV-1:0] vdp_read;
  logic [NV*AW-1:0] vdp_raddr;
  logic [NV*DW-1:0] vdp_rdata;
  logic [NV-1:0] vdp_rvalid;
  logic          vdp_overrun;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_ack;
  logic [AW-1:0] wb_adr_i;
  logic [DW-1:0] wb_dat_i;
  logic [DW-1:0] wb_dat_o;
  logic          wb_we_i;
  logic [1:0]    wb_sel_i;
  logic          wb_stb_i;
  logic          wb_cyc_i;
  logic          wb_ack_o;

  int checks = 0;
  int errors = 0;

  vdpram_arbiter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .NUM_VDP    (NV)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clk_en_vdp  (clk_en_vdp),
    .vdp_read    (vdp_read),
    .vdp_raddr   (vdp_raddr),
    .vdp_rdata   (vdp_rdata),
    .vdp_rvalid  (vdp_rvalid),
`ifdef VDPRAM_OVERRUN_EN
    .vdp_overrun (vdp_overrun),
`endif
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_rdata   (cpu_rdata),
    .cpu_ack     (cpu_ack),
    .wb_adr_i    (wb_adr_i),
    .wb_dat_i    (wb_dat_i),
    .wb_dat_o    (wb_dat_o),
    .wb_we_i     (wb_we_i),
    .wb_sel_i    (wb_sel_i),
    .wb_stb_i    (wb_stb_i),
    .wb_cyc_i    (wb_cyc_i),
    .wb_ack_o    (wb_ack_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

`ifndef VDPRAM_OVERRUN_EN
  assign vdp_overrun = 1'b0;
`endif

  // Reference model state
  logic [DW-1:0] mm [2**AW];
  bit            mp [NV];
  logic [AW-1:0] ml [NV];
  logic [NV*DW-1:0] e_vrd;
  logic [NV-1:0] e_vrv;
  logic [DW-1:0] e_crd;
  logic [DW-1:0] e_wrd;
  bit            e_cack;
  bit            e_wack;
  bit            e_ovr;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < NV; i++) begin
      mp[i] = 0;
      ml[i] = '0;
    end
    e_vrd  = '0;
    e_vrv  = '0;
    e_crd  = '0;
    e_wrd  = '0;
    e_cack = 0;
    e_wack = 0;
    e_ovr  = 0;
  endtask

  task automatic chk_all();
    chk("vdp_rvalid", vdp_rvalid, e_vrv);
    chk("vdp_rdata", vdp_rdata, e_vrd);
    chk("cpu_ack", cpu_ack, e_cack);
    chk("cpu_rdata", cpu_rdata, e_crd);
    chk("wb_ack_o", wb_ack_o, e_wack);
    chk("wb_dat_o", wb_dat_o, e_wrd);
`ifdef VDPRAM_OVERRUN_EN
    chk("vdp_overrun", vdp_overrun, e_ovr);
`endif
  endtask

  // One clock: pick the winner from the priority rules, then update model
  task automatic tick();
    int            g;
    logic [NV-1:0] cap;
    logic [NV*AW-1:0] ra;
    logic [AW-1:0] a;
    logic          cwe;
    logic [AW-1:0] ca;
    logic [DW-1:0] cwd;
    logic          wwe;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [1:0]    ws;
    cap = clk_en_vdp ? vdp_read : '0;
    ra  = vdp_raddr;
    cwe = cpu_we;
    ca  = cpu_addr;
    cwd = cpu_wdata;
    wwe = wb_we_i;
    wa  = wb_adr_i;
    wd  = wb_dat_i;
    ws  = wb_sel_i;
    g = -1;
    for (int i = NV - 1; i >= 0; i--) if (mp[i] || cap[i]) g = i;
    if (g < 0 && cpu_req && !e_cack) g = NV;
    else if (g < 0 && wb_cyc_i && wb_stb_i && !e_wack) g = NV + 1;
    @(posedge clk);
    #1;
    e_vrv  = '0;
    e_cack = (g == NV);
    e_wack = (g == NV + 1);
    if (g >= 0 && g < NV) begin
      a = mp[g] ? ml[g] : ra[g*AW +: AW];
      e_vrd[g*DW +: DW] = mm[a];
      e_vrv[g] = 1'b1;
    end else if (g == NV) begin
      if (cwe) mm[ca] = cwd;
      else e_crd = mm[ca];
    end else if (g == NV + 1) begin
      if (wwe) begin
        for (int b = 0; b < 2; b++) if (ws[b]) mm[wa][b*8 +: 8] = wd[b*8 +: 8];
      end else begin
        e_wrd = mm[wa];
      end
    end
    for (int i = 0; i < NV; i++) begin
      if (g == i) begin
        mp[i] = mp[i] && cap[i];
      end else if (cap[i]) begin
        if (mp[i]) e_ovr = 1;
        mp[i] = 1;
      end
      if (cap[i]) ml[i] = ra[i*AW +: AW];
    end
    chk_all();
  endtask

  task automatic cpu_access(input logic we, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, output logic [DW-1:0] rd);
    int n;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = a;
    cpu_wdata = d;
    n = 0;
    do begin
      tick();
      n++;
    end while (!cpu_ack && n < 20);
    chk("cpu_done", cpu_ack, 1'b1);
    rd = cpu_rdata;
    cpu_req = 1'b0;
  endtask

  task automatic wb_access(input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input logic [1:0] s,
                           output logic [DW-1:0] rd);
    int n;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    wb_we_i  = we;
    wb_adr_i = a;
    wb_dat_i = d;
    wb_sel_i = s;
    n = 0;
    do begin
      tick();
      n++;
    end while (!wb_ack_o && n < 20);
    chk("wb_done", wb_ack_o, 1'b1);
    rd = wb_dat_o;
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    tick();
    chk("wb_ack_pulse", wb_ack_o, 1'b0);
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic [DW-1:0] old;
    int            cnt;
    reset_n    = 1'b0;
    clk_en_vdp = 1'b0;
    vdp_read   = '0;
    vdp_raddr  = '0;
    cpu_req    = 1'b0;
    cpu_we     = 1'b0;
    cpu_addr   = '0;
    cpu_wdata  = '0;
    wb_adr_i   = '0;
    wb_dat_i   = '0;
    wb_we_i    = 1'b0;
    wb_sel_i   = '0;
    wb_stb_i   = 1'b0;
    wb_cyc_i   = 1'b0;
    model_clear();
    #1;
    chk_all();
    #9 reset_n = 1'b1;

    for (int a = 0; a < 32; a++) cpu_access(1'b1, AW'(a), DW'($urandom), rd);
    cpu_access(1'b1, 14'h0123, 16'h005A, rd);
    cpu_access(1'b1, 14'h3FFF, 16'h1111, rd);
    cpu_access(1'b1, 14'h0000, 16'h0000, rd);
    tick();

    // Single channel read
    clk_en_vdp = 1'b1;
    vdp_read   = 2'b01;
    vdp_raddr  = {14'd0, 14'h0123};
    tick();
    clk_en_vdp = 1'b0;
    vdp_read   = '0;
    chk("t1_rvalid", vdp_rvalid, 2'b01);
    chk("t1_data", vdp_rdata[15:0], 16'h005A);

    // Both channels at once
    clk_en_vdp = 1'b1;
    vdp_read   = 2'b11;
    vdp_raddr  = {14'd7, 14'd9};
    tick();
    clk_en_vdp = 1'b0;
    vdp_read   = '0;
    chk("t2_rvalid0", vdp_rvalid, 2'b01);
    chk("t2_data0", vdp_rdata[15:0], mm[9]);
    tick();
    chk("t2_rvalid1", vdp_rvalid, 2'b10);
    chk("t2_data1", vdp_rdata[31:16], mm[7]);

    // CPU write contending with channel 0
    clk_en_vdp = 1'b1;
    vdp_read   = 2'b01;
    vdp_raddr  = {14'd0, 14'd3};
    cpu_req    = 1'b1;
    cpu_we     = 1'b1;
    cpu_addr   = 14'h3FFF;
    cpu_wdata  = 16'h00A5;
    tick();
    clk_en_vdp = 1'b0;
    vdp_read   = '0;
    chk("t3_rvalid", vdp_rvalid, 2'b01);
    chk("t3_ack_wait", cpu_ack, 1'b0);
    tick();
    chk("t3_ack", cpu_ack, 1'b1);
    cpu_req = 1'b0;
    tick();
    cpu_access(1'b0, 14'h3FFF, 16'h0, rd);
    chk("t3_readback", rd, 16'h00A5);

    // Wishbone byte lanes
    wb_access(1'b1, 14'h0000, 16'hBEEF, 2'b10, rd);
    wb_access(1'b0, 14'h0000, 16'h0000, 2'b11, rd);
    chk("t4_lanes", rd, 16'hBE00);

    // Overrun on channel 1 while channel 0 saturates
    cnt = 0;
    clk_en_vdp = 1'b1;
    vdp_read   = 2'b11;
    vdp_raddr  = {14'd10, 14'd1};
    tick();
    cnt += int'(vdp_rvalid[1]);
    vdp_raddr  = {14'd11, 14'd2};
    tick();
    cnt += int'(vdp_rvalid[1]);
    clk_en_vdp = 1'b0;
    vdp_read   = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      cnt += int'(vdp_rvalid[1]);
    end
    chk("t5_one_rvalid", cnt, 1);
    chk("t5_data", vdp_rdata[31:16], mm[11]);
`ifdef VDPRAM_OVERRUN_EN
    chk("t5_overrun", vdp_overrun, 1'b1);
`endif

    // Reset while a CPU write is granted
    old       = mm[5];
    cpu_req   = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 14'd5;
    cpu_wdata = ~old;
    #3 reset_n = 1'b0;
    @(posedge clk);
    #1;
    model_clear();
    chk("t6_cpu_ack", cpu_ack, 1'b0);
    chk("t6_wb_ack", wb_ack_o, 1'b0);
    chk("t6_rvalid", vdp_rvalid, 2'b00);
    chk_all();
    cpu_req = 1'b0;
    #4 reset_n = 1'b1;
    cpu_access(1'b0, 14'd5, 16'h0, rd);
    chk("t6_unchanged", rd, old);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      clk_en_vdp = ($urandom_range(0, 3) == 0);
      vdp_read   = NV'($urandom);
      for (int i = 0; i < NV; i++) vdp_raddr[i*AW +: AW] = AW'($urandom_range(0, 31));
      if ((cpu_req && cpu_ack) || (!cpu_req && $urandom_range(0, 2) == 0)) begin
        cpu_req   = (!cpu_req) || ($urandom_range(0, 1) == 1);
        cpu_we    = $urandom_range(0, 1) == 1;
        cpu_addr  = AW'($urandom_range(0, 31));
        cpu_wdata = DW'($urandom);
      end
      if ((wb_stb_i && wb_ack_o) || (!wb_stb_i && $urandom_range(0, 2) == 0)) begin
        wb_stb_i = (!wb_stb_i) || ($urandom_range(0, 1) == 1);
        wb_cyc_i = wb_stb_i;
        wb_we_i  = $urandom_range(0, 1) == 1;
        wb_adr_i = AW'($urandom_range(0, 31));
        wb_dat_i = DW'($urandom);
        wb_sel_i = 2'($urandom);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
